// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile
// SPI target for a two-byte frame. The first byte is the address and the
// second byte is the data; both are sent MSB first. The block serves a
// 16 x 8-bit register file. SPI inputs are oversampled in the clk domain.
//
// Address byte: bit 7 = 1 selects a read, bit 7 = 0 selects a write.
// Bits 3:0 give the register index. Bits 6:4 are don't-care, so they alias.
//
// Ports:
//   clk, rst       system clock; synchronous active-high reset
//   sclk, cs, mosi SPI inputs, asynchronous to clk (cs is active low)
//   miso, miso_oe  serial read data and its drive enable
//   lcl_addr       local read address
//   lcl_rdata      combinational read of regfile[lcl_addr]
//   wr_stb         one-cycle pulse when an SPI write commits
//   wr_addr        index of the committed write (valid with wr_stb)
//   wr_data        data of the committed write (valid with wr_stb)
//   frame_err      one-cycle pulse when cs rises part-way through a frame
module spi_slave_regfile #(
    parameter logic       CPOL      = 1'b0,
    parameter logic       CPHA      = 1'b0,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [3:0] lcl_addr,
    output logic [7:0] lcl_rdata,
    output logic       wr_stb,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    logic       sclk_m_r, sclk_q_r, sclk_d_r;
    logic       cs_m_r, cs_q_r, cs_d_r;
    logic       mosi_m_r, mosi_q_r;

    logic [7:0] regfile_r [16];
    state_t     state_r;
    logic [4:0] bit_cnt_r;
    logic [6:0] rx_sh_r;
    logic [7:0] tx_sh_r;
    logic       rd_r;
    logic [3:0] idx_r;

    logic       lead_edge_s, trail_edge_s;
    logic       sample_edge_s, shift_edge_s;
    logic       cs_fall_s, cs_rise_s;
    logic [7:0] rx_next_s;
    logic [7:0] rd_word_s;

    assign lead_edge_s   = (sclk_d_r == CPOL) && (sclk_q_r != CPOL);
    assign trail_edge_s  = (sclk_d_r != CPOL) && (sclk_q_r == CPOL);
    assign sample_edge_s = (CPHA == 1'b1) ? trail_edge_s : lead_edge_s;
    assign shift_edge_s  = (CPHA == 1'b1) ? lead_edge_s  : trail_edge_s;
    assign cs_fall_s     = cs_d_r & ~cs_q_r;
    assign cs_rise_s     = ~cs_d_r & cs_q_r;
    assign rx_next_s     = {rx_sh_r, mosi_q_r};
    assign rd_word_s     = regfile_r[rx_next_s[3:0]];
    assign lcl_rdata     = regfile_r[lcl_addr];

    // Two-flop synchronisers plus a delayed copy of sclk and cs for edge detection.
    // The cs flops reset low. A cs that is already low when reset releases
    // therefore produces no falling edge. The block waits until cs has
    // gone high, and only a later falling edge starts a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_m_r <= CPOL;
            sclk_q_r <= CPOL;
            sclk_d_r <= CPOL;
            cs_m_r   <= 1'b0;
            cs_q_r   <= 1'b0;
            cs_d_r   <= 1'b0;
            mosi_m_r <= 1'b0;
            mosi_q_r <= 1'b0;
        end else begin
            sclk_m_r <= sclk;
            sclk_q_r <= sclk_m_r;
            sclk_d_r <= sclk_q_r;
            cs_m_r   <= cs;
            cs_q_r   <= cs_m_r;
            cs_d_r   <= cs_q_r;
            mosi_m_r <= mosi;
            mosi_q_r <= mosi_q_r ^ (mosi_q_r ^ mosi_m_r);
        end
    end

    // Frame FSM, register file and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 5'd0;
            rx_sh_r   <= 7'd0;
            tx_sh_r   <= 8'd0;
            rd_r      <= 1'b0;
            idx_r     <= 4'd0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            wr_stb    <= 1'b0;
            wr_addr   <= 4'd0;
            wr_data   <= 8'd0;
            frame_err <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regfile_r[i] <= RESET_VAL;
            end
        end else begin
            wr_stb    <= 1'b0;
            frame_err <= 1'b0;
            // A cs rise takes priority over any sclk edge seen in the same cycle.
            if (cs_rise_s) begin
                state_r   <= ST_IDLE;
                bit_cnt_r <= 5'd0;
                miso      <= 1'b0;
                miso_oe   <= 1'b0;
                if ((state_r != ST_IDLE) && (bit_cnt_r != 5'd0) && (bit_cnt_r < 5'd16)) begin
                    frame_err <= 1'b1;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (cs_fall_s) begin
                            state_r   <= ST_ADDR;
                            bit_cnt_r <= 5'd0;
                            miso      <= 1'b0;
                            miso_oe   <= 1'b1;
                        end
                    end
                    ST_ADDR: begin
                        if (sample_edge_s) begin
                            rx_sh_r   <= rx_next_s[6:0];
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                            if (bit_cnt_r == 5'd7) begin
                                state_r <= ST_DATA;
                                rd_r    <= rx_next_s[7];
                                idx_r   <= rx_next_s[3:0];
                                // With CPHA=0, bit 7 of the read data must be on
                                // miso before the first leading edge of byte 2.
                                // With CPHA=1, bit 7 is driven on the next leading edge.
                                if (rx_next_s[7]) begin
                                    if (CPHA == 1'b1) begin
                                        tx_sh_r <= rd_word_s;
                                    end else begin
                                        miso    <= rd_word_s[7];
                                        tx_sh_r <= {rd_word_s[6:0], 1'b0};
                                    end
                                end
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sample_edge_s) begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                            if (!rd_r) begin
                                rx_sh_r <= rx_next_s[6:0];
                            end
                            if (bit_cnt_r == 5'd15) begin
                                state_r <= ST_DONE;
                                miso    <= 1'b0;
                                if (!rd_r) begin
                                    regfile_r[idx_r] <= rx_next_s;
                                    wr_stb           <= 1'b1;
                                    wr_addr          <= idx_r;
                                    wr_data          <= rx_next_s;
                                end
                            end
                        // With CPHA=0, the trailing edge that closes the address
                        // byte must not disturb the bit 7 loaded on the 8th sample.
                        end else if (shift_edge_s && rd_r && ((CPHA == 1'b1) || (bit_cnt_r > 5'd8))) begin
                            miso    <= tx_sh_r[7];
                            tx_sh_r <= {tx_sh_r[6:0], 1'b0};
                        end
                    end
                    ST_DONE: begin
                        miso <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile. Instance 0 runs CPOL=0/CPHA=0 and
// instance 1 runs CPOL=1/CPHA=1. A small SPI master task drives the frames.
// Monitors count wr_stb and frame_err pulses.
module tb_spi_slave_regfile;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk0, cs0, mosi0, miso0, miso_oe0, wr_stb0, frame_err0;
    logic       sclk1, cs1, mosi1, miso1, miso_oe1, wr_stb1, frame_err1;
    logic [3:0] lcl_addr0, wr_addr0, lcl_addr1, wr_addr1;
    logic [7:0] lcl_rdata0, wr_data0, lcl_rdata1, wr_data1;

    int         n_vec = 0;
    int         n_err = 0;
    int         stb_cnt0 = 0, stb_cnt1 = 0, fe_cnt0 = 0, fe_cnt1 = 0;
    logic [3:0] last_addr0 = 4'd0, last_addr1 = 4'd0;
    logic [7:0] last_data0 = 8'd0, last_data1 = 8'd0;
    logic [23:0] rx;

    spi_slave_regfile #(.CPOL(1'b0), .CPHA(1'b0), .RESET_VAL(8'h00)) u_dut0 (
        .clk(clk), .rst(rst), .sclk(sclk0), .cs(cs0), .mosi(mosi0),
        .miso(miso0), .miso_oe(miso_oe0), .lcl_addr(lcl_addr0), .lcl_rdata(lcl_rdata0),
        .wr_stb(wr_stb0), .wr_addr(wr_addr0), .wr_data(wr_data0), .frame_err(frame_err0)
    );

    spi_slave_regfile #(.CPOL(1'b1), .CPHA(1'b1), .RESET_VAL(8'h00)) u_dut1 (
        .clk(clk), .rst(rst), .sclk(sclk1), .cs(cs1), .mosi(mosi1),
        .miso(miso1), .miso_oe(miso_oe1), .lcl_addr(lcl_addr1), .lcl_rdata(lcl_rdata1),
        .wr_stb(wr_stb1), .wr_addr(wr_addr1), .wr_data(wr_data1), .frame_err(frame_err1)
    );

    // System clock.
    always #5 clk = ~clk;

    // Pulse monitors, sampled on the falling edge away from DUT updates.
    always @(negedge clk) begin
        if (wr_stb0 === 1'b1) begin
            stb_cnt0++;
            last_addr0 = wr_addr0;
            last_data0 = wr_data0;
        end
        if (wr_stb1 === 1'b1) begin
            stb_cnt1++;
            last_addr1 = wr_addr1;
            last_data1 = wr_data1;
        end
        if (frame_err0 === 1'b1) fe_cnt0++;
        if (frame_err1 === 1'b1) fe_cnt1++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_sclk(input int m, input logic v);
        if (m == 0) sclk0 = v; else sclk1 = v;
    endtask

    task automatic set_cs(input int m, input logic v);
        if (m == 0) cs0 = v; else cs1 = v;
    endtask

    task automatic set_mosi(input int m, input logic v);
        if (m == 0) mosi0 = v; else mosi1 = v;
    endtask

    function automatic logic get_miso(input int m);
        return (m == 0) ? miso0 : miso1;
    endfunction

    // One cs window carries nbits sclk cycles. Bit i of the frame is {a,d}[15-i],
    // and bits past 16 send 0. When i == rst_at, rst pulses before that bit.
    // rx[23-i] holds miso as the master captured it for bit i.
    task automatic xfer(input int m, input logic [7:0] a, input logic [7:0] d,
                        input int nbits, input int rst_at, output logic [23:0] rx_o);
        logic        cpol;
        logic [15:0] f;
        logic        b;
        cpol = (m == 1);
        f    = {a, d};
        rx_o = 24'd0;
        set_cs(m, 1'b0);
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                wait_clk(3);
                rst = 1'b0;
                wait_clk(2);
            end
            b = 1'b0;
            if (i < 16) b = f[15-i];
            if (m == 0) begin
                set_mosi(m, b);
                wait_clk(HALF);
                set_sclk(m, ~cpol);
                rx_o[23-i] = get_miso(m);
                wait_clk(HALF);
                set_sclk(m, cpol);
            end else begin
                set_sclk(m, ~cpol);
                set_mosi(m, b);
                wait_clk(HALF);
                rx_o[23-i] = get_miso(m);
                set_sclk(m, cpol);
                wait_clk(HALF);
            end
        end
        wait_clk(HALF);
        set_cs(m, 1'b1);
        set_mosi(m, 1'b0);
        wait_clk(HALF);
    endtask

    task automatic peek0(input logic [3:0] a, input logic [7:0] exp, input string tag);
        lcl_addr0 = a;
        wait_clk(1);
        check_val(tag, lcl_rdata0, exp);
    endtask

    initial begin
        rst = 1'b1;
        sclk0 = 1'b0; cs0 = 1'b1; mosi0 = 1'b0; lcl_addr0 = 4'd0;
        sclk1 = 1'b1; cs1 = 1'b1; mosi1 = 1'b0; lcl_addr1 = 4'd0;
        wait_clk(4);
        check_val("rst_out0", {miso0, miso_oe0, wr_stb0, frame_err0, wr_addr0, wr_data0}, 32'd0);
        check_val("rst_out1", {miso1, miso_oe1, wr_stb1, frame_err1, wr_addr1, wr_data1}, 32'd0);
        check_val("rst_rd0", lcl_rdata0, 32'h00);
        rst = 1'b0;
        wait_clk(4);

        // Mode 0 write, then sweep the register file.
        xfer(0, 8'h03, 8'hA5, 16, -1, rx);
        check_val("wr_cnt", stb_cnt0, 32'd1);
        check_val("wr_addr", last_addr0, 32'd3);
        check_val("wr_data", last_data0, 32'hA5);
        for (int i = 0; i < 16; i++) begin
            peek0(i[3:0], (i == 3) ? 8'hA5 : 8'h00, $sformatf("reg_%0d", i));
        end

        // Mode 0 reads, direct and through the address alias.
        xfer(0, 8'h83, 8'h00, 16, -1, rx);
        check_val("rd_83", rx[15:8], 32'hA5);
        check_val("rd_addr_miso", rx[23:16], 32'h00);
        xfer(0, 8'hF3, 8'h00, 16, -1, rx);
        check_val("rd_f3", rx[15:8], 32'hA5);
        check_val("rd_no_stb", stb_cnt0, 32'd1);

        // Mode 3 write and read-back.
        xfer(1, 8'h0F, 8'h3C, 16, -1, rx);
        check_val("m3_wr_cnt", stb_cnt1, 32'd1);
        check_val("m3_wr", {last_addr1, last_data1}, 32'hF3C);
        check_val("m3_oe_idle", miso_oe1, 32'd0);
        xfer(1, 8'h8F, 8'h00, 16, -1, rx);
        check_val("m3_rd", rx[15:8], 32'h3C);
        check_val("m3_rd_no_stb", stb_cnt1, 32'd1);
        lcl_addr1 = 4'hF;
        wait_clk(1);
        check_val("m3_reg_f", lcl_rdata1, 32'h3C);

        // cs raised after 10 bits.
        xfer(0, 8'h05, 8'hFF, 10, -1, rx);
        check_val("abort_fe", fe_cnt0, 32'd1);
        check_val("abort_stb", stb_cnt0, 32'd1);
        peek0(4'd5, 8'h00, "abort_reg5");
        xfer(0, 8'h05, 8'h5A, 16, -1, rx);
        check_val("post_abort_wr", {stb_cnt0[7:0], last_addr0, last_data0}, {8'd2, 4'd5, 8'h5A});
        peek0(4'd5, 8'h5A, "post_abort_reg5");
        check_val("post_abort_fe", fe_cnt0, 32'd1);

        // Reset at bit 12 of a write clears the register file and drops the frame.
        xfer(0, 8'h02, 8'h77, 16, 12, rx);
        check_val("rst_mid_stb", stb_cnt0, 32'd2);
        check_val("rst_mid_fe", fe_cnt0 + fe_cnt1, 32'd1);
        check_val("rst_mid_miso_rx", rx[11:8], 32'd0);
        check_val("rst_mid_miso", {miso0, miso_oe0}, 32'd0);
        peek0(4'd2, 8'h00, "rst_mid_reg2");
        peek0(4'd5, 8'h00, "rst_mid_reg5");
        xfer(0, 8'h02, 8'h77, 16, -1, rx);
        check_val("post_rst_wr", {stb_cnt0[7:0], last_addr0, last_data0}, {8'd3, 4'd2, 8'h77});
        xfer(0, 8'h82, 8'h00, 16, -1, rx);
        check_val("post_rst_rd", rx[15:8], 32'h77);

        // 24 sclk cycles in one cs window.
        xfer(0, 8'h01, 8'h11, 24, -1, rx);
        check_val("long_stb", {stb_cnt0[7:0], last_addr0, last_data0}, {8'd4, 4'd1, 8'h11});
        check_val("long_miso", rx, 32'd0);
        check_val("long_fe", fe_cnt0, 32'd1);
        peek0(4'd1, 8'h11, "long_reg1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
